stage_id_hazard: RTL and testbench
==================================

Name: stage_id_hazard

Overview:
- Parametrised successor to the single-issue decode stage. Decodes one MIPS instruction per cycle and reads operands from an internal 32x32 register file.
- Resolves RAW hazards with a NUM_FWD-source bypass network and a load-use interlock. Adds valid/ready handshakes on both sides, branch flush and a saturating stall counter.
- Sits between the IF stage and the EX stage.

Parameters:
- NUM_FWD, 2: number of forwarding sources. Index 0 is the youngest and has the highest priority.
- STALL_CNT_WIDTH, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  IF offers an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_next_pc  in  32  PC of the instruction plus 4
- flush  in  1  squash the held instruction and the incoming one
- fwd_valid  in  NUM_FWD  forwarding source i holds a register result
- fwd_addr  in  5*NUM_FWD  destination of source i, packed as slice [5i+4:5i]
- fwd_data  in  32*NUM_FWD  result of source i
- fwd_pending  in  NUM_FWD  source i data not yet available (load in flight)
- wb_addr  in  5  register-file write address; writes to 0 are ignored
- wb_data  in  32  register-file write data
- out_valid  out  1  decoded instruction present
- out_ready  in  1  EX accepts it
- out_class  out  3  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 7 INVALID
- out_func  out  6  instr[5:0] for ALU_R, 0 otherwise
- out_opcode  out  6  instr[31:26]
- out_rs_data  out  32  resolved rs operand
- out_rt_data  out  32  resolved rt operand
- out_imm  out  32  selected immediate
- out_wb_addr  out  5  destination register; 0 = none
- out_branch_dest  out  32  branch/jump target
- out_link  out  32  in_next_pc+4 for JAL/JALR, 0 otherwise
- stall_cnt  out  STALL_CNT_WIDTH  cycles spent interlocked

Behaviour:
- Reset: all outputs and registered state 0. Register file cleared. in_ready is 0 in the reset cycle.
- Decode:
  - opcode 0: func 08 JR, func 09 JALR, else ALU_R.
  - 02 J, 03 JAL.
  - 01 with rt=1: BGEZ. 04 BEQ, 05 BNE. 07 with rt=0: BGTZ.
  - 09 ADDIU (imm sign-extended), 0d ORI (imm zero-extended), 0f LUI (imm<<16).
  - 23 LW, 2b SW (imm sign-extended).
  - Anything else: INVALID, with out_wb_addr=0. The INVALID record still issues.
- Sources used:
  - rs and rt: ALU_R, SW, BEQ, BNE.
  - rs only: ALU_I, LW, BGEZ, BGTZ, JR, JALR.
  - None: J, JAL, INVALID.
- Writeback address: ALU_R and JALR use rd. ALU_I and LW use rt. JAL uses 31. All others use 0.
- Branch targets:
  - Conditional: in_next_pc + (signext(imm)<<2), modulo 2^32.
  - J/JAL: {in_next_pc[31:28], instr[25:0], 2'b00}.
  - JR/JALR: 0; EX uses out_rs_data.
- Operand resolution, per used source with addr != 0, first match wins:
  1. Lowest-index fwd i with fwd_valid[i] and a matching fwd_addr.
  2. The wb port if wb_addr matches (same-cycle write bypass).
  3. The register file.
- Register 0 always reads 0. An unused source outputs 0.
- Interlock: stall when the winning fwd match has fwd_pending[i]=1. A pending match on a lower-priority source, where a higher one wins, does not stall.
- Handshake:
  - in_ready = !rst && !stall && (!out_valid || out_ready).
  - Accept when in_valid && in_ready. The decoded record is registered and out_valid=1 on the next edge (latency 1).
  - When out_ready && out_valid and nothing is accepted, out_valid drops to 0. A bubble is inserted during a stall.
  - While out_valid && !out_ready, all out_* fields hold stable.
- Flush: on the next edge out_valid=0, and any simultaneous accept is discarded. Flush overrides stall and accept.
- stall_cnt increments each cycle with in_valid && stall && !flush. It saturates at all-ones.
- Register-file write occurs on the edge regardless of stall or flush. rst mid-operation clears state on that edge.

Test Plan:
- Reset, then ADDIU $2,$0,0xFFFF (0x2402FFFF) with out_ready=1 -> next cycle out_valid=1, class 1, imm 0xFFFFFFFF, wb_addr 2.
- wb writes $5=0x1234 in the same cycle as decoding ADDU $3,$5,$0 -> out_rs_data=0x1234.
- fwd0 = {valid, addr 5, data 0xAAAA} and fwd1 = {valid, addr 5, data 0xBBBB}; decode BEQ $5,$5 -> both operands 0xAAAA.
- Load-use: fwd0 = {addr 4, pending} for 3 cycles; decode SW $4,0($1) -> in_ready=0 for 3 cycles, bubbles issued, stall_cnt=3, then issue.
- out_ready=0 for 2 cycles after JAL at next_pc 0x10000004, target field 0x100 -> outputs held; branch_dest=0x10000400, link=0x10000008, wb_addr=31.
- flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0; the following instruction decodes normally.

Source files
------------

// File: rtl/stage_id_hazard.sv
// MIPS decode stage: decodes one instruction per cycle, resolves operands through
// a prioritised bypass network, interlocks on load-use and registers the result for EX.
module stage_id_hazard #(
    parameter int NUM_FWD         = 2,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_next_pc,
    input  logic                       flush,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [5*NUM_FWD-1:0]       fwd_addr,
    input  logic [32*NUM_FWD-1:0]      fwd_data,
    input  logic [NUM_FWD-1:0]         fwd_pending,
    input  logic [4:0]                 wb_addr,
    input  logic [31:0]                wb_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_class,
    output logic [5:0]                 out_func,
    output logic [5:0]                 out_opcode,
    output logic [31:0]                out_rs_data,
    output logic [31:0]                out_rt_data,
    output logic [31:0]                out_imm,
    output logic [4:0]                 out_wb_addr,
    output logic [31:0]                out_branch_dest,
    output logic [31:0]                out_link,
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_INVALID = 3'd7
    } cls_e;

    logic [31:0] rf [32];

    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx, imm_zx, br_target, j_target;

    cls_e        d_cls;
    logic [5:0]  d_func;
    logic [31:0] d_imm, d_dest, d_link;
    logic [4:0]  d_wb;
    logic [1:0]  src_used;

    logic [1:0][4:0]  src_addr;
    logic [1:0][31:0] src_data;
    logic [1:0]       src_pend;
    logic             stall, accept;

    assign opcode    = in_instr[31:26];
    assign rs        = in_instr[25:21];
    assign rt        = in_instr[20:16];
    assign rd        = in_instr[15:11];
    assign func      = in_instr[5:0];
    assign imm_sx    = {{16{in_instr[15]}}, in_instr[15:0]};
    assign imm_zx    = {16'h0000, in_instr[15:0]};
    assign br_target = in_next_pc + {imm_sx[29:0], 2'b00};
    assign j_target  = {in_next_pc[31:28], in_instr[25:0], 2'b00};

    always_comb begin
        d_cls    = CLS_INVALID;
        d_func   = '0;
        d_imm    = '0;
        d_wb     = '0;
        d_dest   = '0;
        d_link   = '0;
        src_used = 2'b00;
        case (opcode)
            6'h00: begin
                src_used = 2'b01;
                if (func == 6'h08) begin
                    d_cls = CLS_JUMP;
                end else if (func == 6'h09) begin
                    d_cls  = CLS_JUMP;
                    d_wb   = rd;
                    d_link = in_next_pc + 32'd4;
                end else begin
                    d_cls    = CLS_ALU_R;
                    d_func   = func;
                    d_wb     = rd;
                    src_used = 2'b11;
                end
            end
            6'h02, 6'h03: begin
                d_cls  = CLS_JUMP;
                d_dest = j_target;
                if (opcode == 6'h03) begin
                    d_wb   = 5'd31;
                    d_link = in_next_pc + 32'd4;
                end
            end
            6'h01, 6'h07: begin
                if ((opcode == 6'h01 && rt == 5'd1) || (opcode == 6'h07 && rt == 5'd0)) begin
                    d_cls    = CLS_BRANCH;
                    d_imm    = imm_sx;
                    d_dest   = br_target;
                    src_used = 2'b01;
                end
            end
            6'h04, 6'h05: begin
                d_cls    = CLS_BRANCH;
                d_imm    = imm_sx;
                d_dest   = br_target;
                src_used = 2'b11;
            end
            6'h09, 6'h0d, 6'h0f: begin
                d_cls    = CLS_ALU_I;
                d_wb     = rt;
                src_used = 2'b01;
                d_imm    = (opcode == 6'h09) ? imm_sx :
                           (opcode == 6'h0d) ? imm_zx : {in_instr[15:0], 16'h0000};
            end
            6'h23: begin
                d_cls    = CLS_LOAD;
                d_imm    = imm_sx;
                d_wb     = rt;
                src_used = 2'b01;
            end
            6'h2b: begin
                d_cls    = CLS_STORE;
                d_imm    = imm_sx;
                src_used = 2'b11;
            end
            default: ;
        endcase
    end

    assign src_addr[0] = rs;
    assign src_addr[1] = rt;

    // Sources are scanned oldest-first so the youngest matching one overwrites last and wins.
    always_comb begin
        src_data = '0;
        src_pend = '0;
        for (int unsigned s = 0; s < 2; s++) begin
            src_data[s] = (wb_addr == src_addr[s]) ? wb_data : rf[src_addr[s]];
            src_pend[s] = 1'b0;
            for (int unsigned k = 0; k < NUM_FWD; k++) begin
                if (fwd_valid[NUM_FWD-1-k] && fwd_addr[5*(NUM_FWD-1-k) +: 5] == src_addr[s]) begin
                    src_data[s] = fwd_data[32*(NUM_FWD-1-k) +: 32];
                    src_pend[s] = fwd_pending[NUM_FWD-1-k];
                end
            end
            if (!src_used[s] || src_addr[s] == 5'd0) begin
                src_data[s] = '0;
                src_pend[s] = 1'b0;
            end
        end
    end

    assign stall    = |src_pend;
    assign in_ready = !rst && !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_class       <= '0;
            out_func        <= '0;
            out_opcode      <= '0;
            out_rs_data     <= '0;
            out_rt_data     <= '0;
            out_imm         <= '0;
            out_wb_addr     <= '0;
            out_branch_dest <= '0;
            out_link        <= '0;
            stall_cnt       <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid       <= 1'b1;
                out_class       <= d_cls;
                out_func        <= d_func;
                out_opcode      <= opcode;
                out_rs_data     <= src_data[0];
                out_rt_data     <= src_data[1];
                out_imm         <= d_imm;
                out_wb_addr     <= d_wb;
                out_branch_dest <= d_dest;
                out_link        <= d_link;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (in_valid && stall && !flush && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_stage_id_hazard.sv
// Scoreboard bench for stage_id_hazard: a reference model predicts each issued
// record and the per-cycle handshake/counter values; a monitor checks EX-side outputs.
module tb_stage_id_hazard;

    localparam int NF   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [2:0]  cls;
        logic [5:0]  func;
        logic [5:0]  opcode;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  wb;
        logic [31:0] dest;
        logic [31:0] link;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst, in_valid, flush, out_ready;
    logic            in_ready, out_valid;
    logic [31:0]     in_instr, in_next_pc, wb_data;
    logic [NF-1:0]   fwd_valid, fwd_pending;
    logic [5*NF-1:0] fwd_addr;
    logic [32*NF-1:0] fwd_data;
    logic [4:0]      wb_addr;
    logic [2:0]      out_class;
    logic [5:0]      out_func, out_opcode;
    logic [31:0]     out_rs_data, out_rt_data, out_imm, out_branch_dest, out_link;
    logic [4:0]      out_wb_addr;
    logic [CW-1:0]   stall_cnt;

    int   vectors = 0;
    int   miscompares = 0;
    rec_t q[$];
    bit [31:0] mrf [32] = '{default: 32'h0};
    bit   exp_ov = 1'b0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    stage_id_hazard #(.NUM_FWD(NF), .STALL_CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_next_pc(in_next_pc), .flush(flush),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_func(out_func), .out_opcode(out_opcode), .out_rs_data(out_rs_data),
        .out_rt_data(out_rt_data), .out_imm(out_imm), .out_wb_addr(out_wb_addr),
        .out_branch_dest(out_branch_dest), .out_link(out_link), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic rec_t dut_rec();
        return {out_class, out_func, out_opcode, out_rs_data, out_rt_data, out_imm,
                out_wb_addr, out_branch_dest, out_link};
    endfunction

    // Operand value as the register file would hold it after all older writes land.
    function automatic logic [31:0] src_val(input logic [4:0] a, output bit pend);
        logic [4:0]  fa;
        logic [31:0] fd;
        pend = 1'b0;
        if (a == 5'd0) return 32'h0;
        for (int i = 0; i < NF; i++) begin
            fa = fwd_addr[5*i +: 5];
            fd = fwd_data[32*i +: 32];
            if (fwd_valid[i] && fa == a) begin
                pend = fwd_pending[i];
                return fd;
            end
        end
        if (wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    function automatic rec_t model(output bit stall);
        rec_t r;
        bit use_s, use_t, p1, p2, br;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] sx;
        op = in_instr[31:26]; fn = in_instr[5:0];
        rs = in_instr[25:21]; rt = in_instr[20:16]; rd = in_instr[15:11];
        sx = {{16{in_instr[15]}}, in_instr[15:0]};
        r = '0; r.opcode = op; r.cls = 3'd7;
        use_s = 0; use_t = 0; br = 0;
        if (op == 6'h00 && fn == 6'h08) begin r.cls = 5; use_s = 1; end
        else if (op == 6'h00 && fn == 6'h09) begin r.cls = 5; use_s = 1; r.wb = rd; r.link = in_next_pc + 4; end
        else if (op == 6'h00) begin r.cls = 0; r.func = fn; use_s = 1; use_t = 1; r.wb = rd; end
        else if (op == 6'h02 || op == 6'h03) begin
            r.cls = 5;
            r.dest = (in_next_pc & 32'hF000_0000) + (in_instr[25:0] * 4);
            if (op == 6'h03) begin r.wb = 31; r.link = in_next_pc + 4; end
        end
        else if ((op == 6'h01 && rt == 1) || (op == 6'h07 && rt == 0)) begin br = 1; use_s = 1; end
        else if (op == 6'h04 || op == 6'h05) begin br = 1; use_s = 1; use_t = 1; end
        else if (op == 6'h09) begin r.cls = 1; use_s = 1; r.wb = rt; r.imm = sx; end
        else if (op == 6'h0d) begin r.cls = 1; use_s = 1; r.wb = rt; r.imm = in_instr[15:0]; end
        else if (op == 6'h0f) begin r.cls = 1; use_s = 1; r.wb = rt; r.imm = in_instr[15:0] * 65536; end
        else if (op == 6'h23) begin r.cls = 2; use_s = 1; r.wb = rt; r.imm = sx; end
        else if (op == 6'h2b) begin r.cls = 3; use_s = 1; use_t = 1; r.imm = sx; end
        if (br) begin r.cls = 4; r.imm = sx; r.dest = in_next_pc + sx * 4; end
        p1 = 0; p2 = 0;
        if (use_s) r.rs_data = src_val(rs, p1);
        if (use_t) r.rt_data = src_val(rt, p2);
        stall = p1 | p2;
        return r;
    endfunction

    // One clock: inputs already applied; checks at +7 after the edge, then advances the model.
    task automatic cycle();
        rec_t r;
        bit   st, exp_ready;
        #6;
        r = model(st);
        exp_ready = !rst && !st && (!exp_ov || out_ready);
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_ready});
        chk("out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
        chk("stall_cnt", 32'(stall_cnt), exp_cnt);
        if (rst) begin
            q.delete();
            exp_ov = 0;
            exp_cnt = 0;
            foreach (mrf[i]) mrf[i] = 0;
        end else begin
            if (in_valid && st && !flush && exp_cnt < CMAX) exp_cnt++;
            if (flush) begin
                if (exp_ov && !out_ready && q.size() > 0) void'(q.pop_back());
                exp_ov = 0;
            end else if (in_valid && exp_ready) begin
                q.push_back(r);
                exp_ov = 1;
            end else if (out_ready) begin
                exp_ov = 0;
            end
            if (wb_addr != 0) mrf[wb_addr] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1;
        fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
        wb_addr = 0; wb_data = 0; in_instr = 0; in_next_pc = 0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        fn = 6'($urandom);
        case ($urandom_range(0, 13))
            0: op = 6'h00;
            1: begin op = 6'h00; fn = 6'h08; end
            2: begin op = 6'h00; fn = 6'h09; end
            3: op = 6'h02;
            4: op = 6'h03;
            5: begin op = 6'h01; if ($urandom_range(0, 3) != 0) rt = 5'd1; end
            6: op = 6'h04;
            7: op = 6'h05;
            8: begin op = 6'h07; if ($urandom_range(0, 3) != 0) rt = 5'd0; end
            9: op = 6'h09;
            10: op = 6'h0d;
            11: op = 6'h0f;
            12: op = ($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2b;
            default: op = 6'($urandom);
        endcase
        return {op, rs, rt, rd, 5'($urandom), fn};
    endfunction

    // Monitor: checks a held record every cycle and consumes it on transfer.
    initial begin
        rec_t got;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got = dut_rec();
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL record: got %h expected none queued at %0t", got, $time);
                end else begin
                    if (got !== q[0]) begin
                        miscompares++;
                        $display("FAIL record: got %h expected %h at %0t", got, q[0], $time);
                    end
                    if (out_ready === 1'b1) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 0;
        chk("reset_fields", {29'h0, |dut_rec()}, 32'h0);

        in_valid = 1; in_instr = 32'h2402FFFF; in_next_pc = 32'h100;
        cycle();
        idle(); cycle();

        in_valid = 1; in_instr = 32'h00A01821; wb_addr = 5; wb_data = 32'h1234;
        cycle();
        idle(); cycle();

        in_valid = 1; in_instr = 32'h10A50004; in_next_pc = 32'h200;
        fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
        cycle();
        idle(); cycle();

        in_valid = 1; in_instr = 32'hAC240000; fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd4};
        fwd_pending = 2'b01;
        repeat (3) cycle();
        chk("load_use_stall_cnt", 32'(stall_cnt), 32'd3);
        fwd_pending = 2'b00; fwd_data = {32'h0, 32'h5555};
        cycle();
        idle(); cycle();

        in_valid = 1; in_instr = 32'h0C000100; in_next_pc = 32'h10000004;
        cycle();
        idle(); out_ready = 0;
        repeat (2) cycle();
        chk("jal_dest", out_branch_dest, 32'h10000400);
        chk("jal_link", out_link, 32'h10000008);
        out_ready = 1;
        cycle();

        in_valid = 1; in_instr = 32'h2402FFFF; out_ready = 0;
        cycle();
        in_instr = 32'h24030007; flush = 1;
        cycle();
        flush = 0; out_ready = 1; in_instr = 32'h3404ABCD;
        cycle();
        idle(); repeat (2) cycle();

        for (int n = 0; n < 3000; n++) begin
            rst         = (n == 1500);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_instr    = gen_instr();
            in_next_pc  = $urandom & 32'hFFFF_FFFC;
            flush       = ($urandom_range(0, 15) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            fwd_valid   = NF'($urandom);
            fwd_pending = NF'($urandom_range(0, 4) == 0 ? $urandom : 0);
            for (int i = 0; i < NF; i++) begin
                fwd_addr[5*i +: 5]  = 5'($urandom_range(0, 7));
                fwd_data[32*i +: 32] = $urandom;
            end
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            cycle();
        end
        rst = 0;

        idle();
        repeat (3) cycle();
        chk("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
